// File: rtl/blit_pkg.sv
// Shared types for the blitter SDRAM write path: one queued word write
// and the byte-lane expansion used when merging pixel writes.
package blit_pkg;

   localparam int BLIT_ADDR_W = 26;

   typedef struct packed {
      logic [BLIT_ADDR_W-1:2] addr;
      logic [31:0]            data;
      logic [3:0]             mask;
   } blit_wword_t;

   function automatic logic [31:0] blit_lane_mask(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

endpackage

// File: rtl/blit_wfifo.sv
// Small FIFO of word writes. The head is held in a register updated one
// edge ahead so the SDRAM-facing outputs come straight from flops.
module blit_wfifo
   import blit_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  blit_wword_t push_word,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output blit_wword_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   blit_wword_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;
   blit_wword_t   head_nxt;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rd_next = rd_ptr + AW'(1);

   // Look-ahead of what the head will be after this edge's push/pop.
   always_comb begin
      head_nxt = head;
      if (pop_ok) begin
         if (count > (AW+1)'(1))
            head_nxt = mem[rd_next];
         else if (push_ok)
            head_nxt = push_word;
         else
            head_nxt = '0;
      end else if (empty && push_ok) begin
         head_nxt = push_word;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         head <= head_nxt;
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_next;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/blit_writemem.sv
// Blitter write path: coalesces byte-masked pixel writes into 32-bit words,
// queues them and issues masked single-word writes to the SDRAM arbiter.
module blit_writemem
   import blit_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [BLIT_ADDR_W-1:0] wr_address,
   input  logic [31:0]            wr_data,
   input  logic [3:0]             wr_mask,
   input  logic                   flush,
   output logic                   idle,
   output logic                   sdram_request,
   input  logic                   sdram_ready,
   output logic [BLIT_ADDR_W-1:0] sdram_address,
   output logic [31:0]            sdram_wdata,
   output logic [3:0]             sdram_wmask,
   output logic                   inval_valid,
   output logic [BLIT_ADDR_W-1:0] inval_address
);

   logic                   cb_valid, cb_valid_nxt;
   logic [BLIT_ADDR_W-1:2] cb_addr, cb_addr_nxt;
   logic [31:0]            cb_data, cb_data_nxt;
   logic [3:0]             cb_mask, cb_mask_nxt;
   logic                   flush_pending, pending_nxt;
   logic [7:0]             idle_cnt;

   logic        same_word, wr_fire, wr_load;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_room;
   logic        timed_out, flush_req;
   logic [31:0] lane, base_data, new_data;
   logic [3:0]  new_mask;
   blit_wword_t fifo_word, fifo_head;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^wr_address[1:0];

   assign same_word = cb_valid & (wr_address[BLIT_ADDR_W-1:2] == cb_addr);
   // Never looks at sdram_ready, so the blitter sees a glitch-free handshake.
   assign wr_ready  = (wr_mask == 4'h0) | ~cb_valid | same_word | ~fifo_full;
   assign wr_fire   = wr_valid & wr_ready;
   assign wr_load   = wr_fire & (wr_mask != 4'h0);

   assign fifo_pop  = ~fifo_empty & sdram_ready;
   assign fifo_room = ~fifo_full | fifo_pop;
   assign timed_out = (idle_cnt == 8'(TIMEOUT));
   assign flush_req = flush | flush_pending;

   assign lane      = blit_lane_mask(wr_mask);
   assign base_data = same_word ? cb_data : 32'h0;
   assign new_data  = (base_data & ~lane) | (wr_data & lane);
   assign new_mask  = (same_word ? cb_mask : 4'h0) | wr_mask;

   always_comb begin
      cb_valid_nxt = cb_valid;
      cb_addr_nxt  = cb_addr;
      cb_data_nxt  = cb_data;
      cb_mask_nxt  = cb_mask;
      pending_nxt  = flush_pending;
      fifo_push    = 1'b0;
      fifo_word.addr = cb_addr;
      fifo_word.data = cb_data;
      fifo_word.mask = cb_mask;
      if (wr_load) begin
         if (cb_valid && !same_word) begin
            fifo_push    = 1'b1;
            cb_valid_nxt = 1'b1;
            cb_addr_nxt  = wr_address[BLIT_ADDR_W-1:2];
            cb_data_nxt  = new_data;
            cb_mask_nxt  = new_mask;
            pending_nxt  = flush;
         end else if (fifo_room && (flush_req || timed_out ||
                                    (cb_valid && cb_mask == 4'hF))) begin
            // Flush lands after the merge: the merged word goes straight out.
            fifo_push      = 1'b1;
            fifo_word.addr = wr_address[BLIT_ADDR_W-1:2];
            fifo_word.data = new_data;
            fifo_word.mask = new_mask;
            cb_valid_nxt   = 1'b0;
            cb_mask_nxt    = 4'h0;
            pending_nxt    = 1'b0;
         end else begin
            cb_valid_nxt = 1'b1;
            cb_addr_nxt  = wr_address[BLIT_ADDR_W-1:2];
            cb_data_nxt  = new_data;
            cb_mask_nxt  = new_mask;
            pending_nxt  = flush_req;
         end
      end else if (cb_valid) begin
         if (fifo_room && (flush_req || timed_out || cb_mask == 4'hF)) begin
            fifo_push    = 1'b1;
            cb_valid_nxt = 1'b0;
            cb_mask_nxt  = 4'h0;
            pending_nxt  = 1'b0;
         end else begin
            pending_nxt = flush_req;
         end
      end else begin
         pending_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cb_valid      <= 1'b0;
         cb_addr       <= '0;
         cb_data       <= '0;
         cb_mask       <= '0;
         flush_pending <= 1'b0;
         idle_cnt      <= '0;
      end else begin
         cb_valid      <= cb_valid_nxt;
         cb_addr       <= cb_addr_nxt;
         cb_data       <= cb_data_nxt;
         cb_mask       <= cb_mask_nxt;
         flush_pending <= pending_nxt;
         if (wr_fire || fifo_push)
            idle_cnt <= '0;
         else if (cb_valid && !wr_valid && !timed_out)
            idle_cnt <= idle_cnt + 8'd1;
      end
   end

   blit_wfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_word (fifo_word),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign sdram_request = ~fifo_empty;
   assign sdram_address = {fifo_head.addr, 2'b00};
   assign sdram_wdata   = fifo_head.data;
   assign sdram_wmask   = fifo_head.mask;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inval_valid   <= 1'b0;
         inval_address <= '0;
      end else begin
         inval_valid <= fifo_pop;
         if (fifo_pop)
            inval_address <= {fifo_head.addr, 2'b00};
      end
   end

   assign idle = ~cb_valid & fifo_empty & ~wr_valid & ~flush_pending;

endmodule

// File: tb/tb_blit_writemem.sv
// Bench for blit_writemem: directed vectors and sequences checked through
// an expected-write queue, plus a random run checked as a byte image.
module tb_blit_writemem;

   localparam int TIMEOUT = 16;
   localparam int DEPTH   = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [25:0] wr_address = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_mask = '0;
   logic        flush = 1'b0;
   logic        idle;
   logic        sdram_request;
   logic        sdram_ready = 1'b0;
   logic [25:0] sdram_address;
   logic [31:0] sdram_wdata;
   logic [3:0]  sdram_wmask;
   logic        inval_valid;
   logic [25:0] inval_address;

   always #5 clk = ~clk;

   blit_writemem #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_address    (wr_address),
      .wr_data       (wr_data),
      .wr_mask       (wr_mask),
      .flush         (flush),
      .idle          (idle),
      .sdram_request (sdram_request),
      .sdram_ready   (sdram_ready),
      .sdram_address (sdram_address),
      .sdram_wdata   (sdram_wdata),
      .sdram_wmask   (sdram_wmask),
      .inval_valid   (inval_valid),
      .inval_address (inval_address)
   );

   typedef struct {
      logic [25:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } exp_t;

   typedef struct {
      logic [25:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      bit          has_exp;
      logic [31:0] exp_data;
      logic [3:0]  exp_mask;
   } vec_t;

   exp_t       exp_q[$];
   vec_t       vecs[5];
   int         checks = 0;
   int         failures = 0;
   int         fire_cnt = 0;
   bit         sb_mode = 1'b1;
   bit         rand_ready = 1'b0;
   logic [7:0] exp_mem[64];
   logic [7:0] dut_mem[64];

   function automatic void chk(input string name, input bit ok,
                               input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   task automatic expect_word(input logic [25:0] a, input logic [31:0] d,
                              input logic [3:0] m);
      exp_t e;
      e.addr = a; e.data = d; e.mask = m;
      exp_q.push_back(e);
   endtask

   // Monitor: invalidate timing, hold stability, and write scoreboard.
   bit          inv_pend = 1'b0;
   logic [25:0] inv_addr = '0;
   bit          hold_prev = 1'b0;
   logic [61:0] prev_word = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         inv_pend  = 1'b0;
         hold_prev = 1'b0;
      end else begin
         if (inv_pend)
            chk("inval", inval_valid && inval_address == inv_addr,
                {inval_valid, inval_address}, {1'b1, inv_addr});
         else if (inval_valid)
            chk("inval_spurious", 1'b0, inval_valid, 0);
         if (hold_prev)
            chk("hold_stable",
                {sdram_address, sdram_wdata, sdram_wmask} == prev_word,
                {sdram_address, sdram_wdata, sdram_wmask}, prev_word);
         hold_prev = sdram_request && !sdram_ready;
         prev_word = {sdram_address, sdram_wdata, sdram_wmask};
         inv_pend  = sdram_request && sdram_ready;
         inv_addr  = sdram_address;
         if (sdram_request && sdram_ready) begin
            fire_cnt++;
            if (sb_mode) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", 1'b0,
                      {sdram_address, sdram_wdata, sdram_wmask}, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("sdram_word",
                      {sdram_address, sdram_wdata, sdram_wmask} ==
                      {e.addr, e.data, e.mask},
                      {sdram_address, sdram_wdata, sdram_wmask},
                      {e.addr, e.data, e.mask});
               end
            end else begin
               for (int b = 0; b < 4; b++)
                  if (sdram_wmask[b])
                     dut_mem[int'(sdram_address[5:0]) + b] = sdram_wdata[8*b +: 8];
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         sdram_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic do_write(input logic [25:0] a, input logic [31:0] d,
                           input logic [3:0] m, input bit f);
      int n = 0;
      wr_valid = 1'b1; wr_address = a; wr_data = d; wr_mask = m; flush = f;
      @(negedge clk);
      while (!wr_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("wr_accept", wr_ready, n, 0);
      @(posedge clk);
      #1;
      wr_valid = 1'b0; flush = 1'b0; wr_mask = 4'h0;
      if (!sb_mode && a < 26'd64)
         for (int b = 0; b < 4; b++)
            if (m[b]) exp_mem[int'(a[5:2]) * 4 + b] = d[8*b +: 8];
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = idle && !sdram_request && exp_q.size() == 0;
      end
      chk(name, done, exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int bad;
      int snap;

      vecs[0] = '{26'h500, 32'hDEADBEEF, 4'b1111, 1'b1, 32'hDEADBEEF, 4'b1111};
      vecs[1] = '{26'h504, 32'h12345678, 4'b0101, 1'b1, 32'h00340078, 4'b0101};
      vecs[2] = '{26'h508, 32'hCAFEF00D, 4'b1000, 1'b1, 32'hCA000000, 4'b1000};
      vecs[3] = '{26'h50C, 32'h0BADF00D, 4'b0110, 1'b1, 32'h00ADF000, 4'b0110};
      vecs[4] = '{26'h510, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, 4'h0};
      for (int i = 0; i < 64; i++) begin
         exp_mem[i] = 8'h0;
         dut_mem[i] = 8'h0;
      end

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_wr_ready", wr_ready == 1'b1, wr_ready, 1);
      chk("rst_idle", idle == 1'b1, idle, 1);
      chk("rst_request", sdram_request == 1'b0, sdram_request, 0);
      chk("rst_sdram_out", {sdram_address, sdram_wdata, sdram_wmask} == '0,
          {sdram_address, sdram_wdata, sdram_wmask}, 0);
      chk("rst_inval", {inval_valid, inval_address} == '0,
          {inval_valid, inval_address}, 0);
      @(posedge clk);
      #1;

      // Four byte writes coalesce into one full word.
      sdram_ready = 1'b1;
      expect_word(26'h100, 32'h44332211, 4'hF);
      do_write(26'h100, 32'h00000011, 4'b0001, 1'b0);
      do_write(26'h100, 32'h00002200, 4'b0010, 1'b0);
      do_write(26'h100, 32'h00330000, 4'b0100, 1'b0);
      do_write(26'h100, 32'h44000000, 4'b1000, 1'b0);
      wait_drain("drain_coalesce");

      // Partial word leaves only after the idle timeout.
      expect_word(26'h200, 32'h0000BEEF, 4'b0011);
      do_write(26'h200, 32'h0000BEEF, 4'b0011, 1'b0);
      n = 0;
      while (!sdram_request && n < 40) begin
         @(negedge clk);
         if (!sdram_request) n++;
      end
      chk("timeout_cycles", n >= TIMEOUT && n <= TIMEOUT + 2, n, TIMEOUT + 1);
      wait_drain("drain_timeout");
      chk("idle_after_timeout", idle == 1'b1, idle, 1);

      // Vector table: single write followed by a flush pulse.
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].has_exp)
            expect_word(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_mask);
         do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, 1'b0);
         pulse_flush();
         wait_drain("drain_vec");
      end

      // Fill FIFO with the arbiter stalled, then drain in order.
      sdram_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         expect_word(26'h300 + 26'(4 * i), 32'h000000A0 + 32'(i), 4'b0001);
         wr_valid = 1'b1; wr_address = 26'h300 + 26'(4 * i);
         wr_data = 32'h000000A0 + 32'(i); wr_mask = 4'b0001;
         @(negedge clk);
         chk("fill_ready", wr_ready == (i < 5), wr_ready, (i < 5));
         if (i < 5) begin
            @(posedge clk);
            #1;
         end
      end
      chk("fill_request", sdram_request == 1'b1, sdram_request, 1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 sdram_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wr_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("fill_resume", wr_ready == 1'b1, wr_ready, 1);
      @(posedge clk);
      #1 wr_valid = 1'b0; wr_mask = 4'h0;
      wait_drain("drain_fill");

      // Flush in the same cycle as a merging write.
      expect_word(26'h400, 32'h0000BBAA, 4'b0011);
      do_write(26'h400, 32'h000000AA, 4'b0001, 1'b0);
      do_write(26'h400, 32'h0000BB00, 4'b0010, 1'b1);
      wait_drain("drain_flush_merge");

      // Random writes against a randomly stalling arbiter.
      sb_mode = 1'b0;
      rand_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         do_write(26'($urandom_range(0, 15)) << 2, $urandom,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2 sdram_ready = 1'b1;
      wait_drain("drain_random");
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (exp_mem[i] !== dut_mem[i]) bad++;
      chk("random_image", bad == 0, bad, 0);
      sb_mode = 1'b1;

      // Reset with three words queued and one partial word.
      sdram_ready = 1'b0;
      do_write(26'h600, 32'h1, 4'b0001, 1'b0);
      do_write(26'h604, 32'h2, 4'b0001, 1'b0);
      do_write(26'h608, 32'h3, 4'b0001, 1'b0);
      do_write(26'h60C, 32'h4, 4'b0001, 1'b0);
      chk("pre_reset_request", sdram_request == 1'b1, sdram_request, 1);
      snap = fire_cnt;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("reset_request", sdram_request == 1'b0, sdram_request, 0);
      chk("reset_idle", idle == 1'b1, idle, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      sdram_ready = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_write_after_reset", fire_cnt == snap, fire_cnt, snap);
      chk("post_reset_idle", idle == 1'b1 && sdram_request == 1'b0,
          {idle, sdram_request}, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/blit_writemem.md
Name: blit_writemem

Overview:
- Write-side companion to the blitter's SDRAM read cache.
- Accepts byte-masked pixel writes from the blitter back end and coalesces consecutive writes to the same 32-bit word.
- Queues completed words in a small FIFO and issues single-word masked write requests to the SDRAM arbiter.
- Reports idle so the blitter can signal completion, and pulses an invalidate so the read cache can drop stale lines.

Parameters:
FIFO_DEPTH, 4, number of queued word writes (power of two, >=2)
TIMEOUT, 16, idle cycles before a partial coalesce word is flushed (1..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  write request present
wr_ready  out  1  write request accepted this cycle when wr_valid&wr_ready
wr_address  in  26  byte address; [1:0] ignored
wr_data  in  32  write data, byte lanes aligned to address[1:0]=0
wr_mask  in  4  byte enables
flush  in  1  single-cycle pulse: force coalesce word into FIFO
idle  out  1  coalesce buffer empty, FIFO empty, no wr_valid
sdram_request  out  1  write request to SDRAM arbiter
sdram_ready  in  1  arbiter accepts when sdram_request&sdram_ready
sdram_address  out  26  word address, [1:0]=0
sdram_wdata  out  32  write data
sdram_wmask  out  4  byte enables
inval_valid  out  1  one-cycle pulse per accepted SDRAM write
inval_address  out  26  address of that write (read cache uses [10:6])

Behaviour:
- Reset (async assert, sync release): coalesce buffer empty (cb_valid=0, cb_mask=0), FIFO empty, idle counter 0. Outputs: sdram_request=0, sdram_address/wdata/wmask=0, inval_valid=0, inval_address=0, wr_ready=1, idle=1.
- Coalesce buffer holds cb_addr[25:2], cb_data, cb_mask.
- Accept rules:
  - wr_mask=0: accept, no state change.
  - cb empty: load.
  - wr_address[25:2]==cb_addr: merge; lanes with wr_mask set overwrite, cb_mask |= wr_mask.
  - Different word: push cb into FIFO and load new. Accepted only if FIFO not full; otherwise wr_ready=0.
  - wr_ready is combinational from cb/FIFO state and wr_address; it never depends on sdram_ready.
- Auto-flush: push cb into FIFO at the next edge when FIFO has room and any of the following holds:
  - cb_mask==4'hF after the update;
  - the flush pulse is high;
  - the idle counter reaches TIMEOUT.
- Flush timing and priority:
  - A flush pulse arriving while the FIFO is full is latched as pending until the push completes.
  - A flush in the same cycle as an accepted write applies after the merge, so the merged word is flushed.
- Idle counter: clears on any accepted write or push. Increments while cb_valid and no wr_valid. Saturates at TIMEOUT.
- FIFO push and pop may occur in the same cycle. When full, push+pop is legal only if the pop frees the slot: full-FIFO acceptance may use sdram_request&sdram_ready of the same cycle.
- SDRAM side:
  - sdram_request = FIFO not empty.
  - sdram_address/wdata/wmask show the FIFO head, registered so the outputs are glitch-free. They remain stable while request&!ready.
  - Pop on request&ready.
  - inval_valid/inval_address are registered the cycle after a pop, carrying the popped address.
- Latency: a full-mask write accepted at edge N is in cb at N; pushed at N+1; sdram_request=1 in cycle after N+1. Best-case throughput is one word per clock.
- Ordering: writes leave in acceptance order; no reordering or FIFO-level merging.
- idle = !cb_valid & FIFO empty & !wr_valid & !flush_pending.
- Reset mid-operation: all queued and partial data is discarded; no request is issued after deassert.

Decomposition:
- Shared package blit_pkg holds:
  - typedef blit_wword_t {addr[25:2], data[31:0], mask[3:0]};
  - localparam BLIT_ADDR_W=26.
- One sub-module, blit_wfifo: a parameterized synchronous FIFO of blit_wword_t with push/pop/full/empty and same-cycle push+pop.

Test Plan:
- Four writes to 0x000100, masks 0001,0010,0100,1000, data bytes 11,22,33,44 -> one SDRAM write addr 0x000100, wdata 0x44332211, wmask F; inval_address 0x000100 one cycle after accept.
- Write 0x000200 mask 0011 data 0x0000BEEF, then no input -> request after TIMEOUT (16) idle cycles with wmask 0011; idle=1 after pop.
- Writes to 0x000300, 0x000304, 0x000308 (mask 0001 each) with sdram_ready=0 and FIFO_DEPTH=4 -> wr_ready stays 1 until FIFO full, then wr_ready=0; raising sdram_ready drains in address order 300,304,308,... with no loss.
- Write mask 0001 then flush in the same cycle as a second merge write mask 0010 to same word -> a single SDRAM write with wmask 0011.
- sdram_ready toggled randomly over 200 random writes -> scoreboard byte image matches expected memory; sdram_address/wdata stable while request&!ready.
- Assert reset low mid-burst with 3 queued words -> sdram_request=0 immediately, idle=1, no write after release.
